riscv_mem_stage: RTL

- MEM stage of the 5-stage RV32I pipeline. Consumes EX/MEM control and data, and performs byte/half/word loads and stores on a synchronous-read data memory.
- Produces the registered MEM/WB outputs (ALU result, PC+4, load data, rd, write-back controls) that feed the write-back mux.
- Flags misaligned and out-of-range accesses, and suppresses their side effects.

---
 rtl/riscv_mem_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/riscv_mem_stage.sv
// MEM stage of the RV32I pipeline: synchronous-read data RAM, aligned/extended loads, fault flags.
// Optional memory-mapped output register at 32'hFFFF_0000 enabled by `define DMEM_MMIO_EN.
module riscv_mem_stage #(
  parameter logic [31:0] DMEM_BASE = 32'h0010_0000,
  parameter int unsigned DMEM_SIZE = 32768,
  parameter              DMEM_FILE = "data.mif"
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL,
  input  logic        EM_VALID,
  input  logic [31:0] EM_ADDR,
  input  logic [31:0] EM_WDATA,
  input  logic [31:0] EM_PC4,
  input  logic [4:0]  EM_RD,
  input  logic [1:0]  EM_MEMREAD,
  input  logic [1:0]  EM_MEMWRITE,
  input  logic        EM_DMSE,
  input  logic [1:0]  EM_MEMTOREG,
  input  logic        EM_REGWRITE,
  output logic        MW_VALID,
  output logic [31:0] MW_RD_VAL,
  output logic [31:0] MW_PC4,
  output logic [4:0]  MW_RD,
  output logic [1:0]  MW_MEMTOREG,
  output logic        MW_REGWRITE,
  output logic [31:0] MW_MEM_DATA,
  output logic [1:0]  MW_FAULT
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] MMIO_OUT
`endif
);

  localparam int unsigned IW         = $clog2(DMEM_SIZE);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_SIZE * 4);

  logic [31:0]   mem [DMEM_SIZE];
  logic [31:0]   rdata_q;
  logic [1:0]    ld_size_q;
  logic [1:0]    ld_off_q;
  logic          ld_sx_q;
  logic          wr_block_q;

  logic [1:0]    size;
  logic [31:0]   off;
  logic [IW-1:0] idx;
  logic          in_range, misal, mmio_hit, access_v, ok, do_store, do_load;
  logic [1:0]    fault;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;

  assign size     = (EM_MEMREAD != 2'b00) ? EM_MEMREAD : EM_MEMWRITE;
  assign off      = EM_ADDR - DMEM_BASE;
  assign idx      = off[IW+1:2];
  assign in_range = off < DMEM_BYTES;
  assign misal    = ((size == 2'b10) && EM_ADDR[0]) ||
                    ((size == 2'b11) && (EM_ADDR[1:0] != 2'b00));
`ifdef DMEM_MMIO_EN
  assign mmio_hit = (EM_ADDR == 32'hFFFF_0000) && (size == 2'b11);
`else
  assign mmio_hit = 1'b0;
`endif
  assign access_v = EM_VALID && ((EM_MEMREAD != 2'b00) || (EM_MEMWRITE != 2'b00));

  always_comb begin
    fault = 2'b00;
    if (access_v) begin
      if (misal)                      fault = 2'b01;
      else if (!in_range && !mmio_hit) fault = 2'b10;
    end
  end

  assign ok       = access_v && (fault == 2'b00);
  assign do_store = ok && (EM_MEMWRITE != 2'b00) && !STALL && !wr_block_q && !mmio_hit;
  assign do_load  = ok && (EM_MEMREAD != 2'b00);

  always_comb begin
    be = '0;
    wd = EM_WDATA;
    case (EM_MEMWRITE)
      2'b01: begin
        be = 4'b0001 << EM_ADDR[1:0];
        wd = {4{EM_WDATA[7:0]}};
      end
      2'b10: begin
        be = EM_ADDR[1] ? 4'b1100 : 4'b0011;
        wd = {2{EM_WDATA[15:0]}};
      end
      2'b11:   be = 4'b1111;
      default: be = '0;
    endcase
  end

  // Held high by RST and cleared one edge later, so the edge that releases reset never writes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) wr_block_q <= 1'b1;
    else     wr_block_q <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (do_store) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
    if (!STALL) begin
`ifdef DMEM_MMIO_EN
      rdata_q <= mmio_hit ? MMIO_OUT : mem[idx];
`else
      rdata_q <= mem[idx];
`endif
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      MMIO_OUT <= '0;
    else if (ok && mmio_hit && (EM_MEMWRITE == 2'b11) && !STALL && !wr_block_q)
      MMIO_OUT <= EM_WDATA;
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MW_VALID    <= 1'b0;
      MW_RD_VAL   <= '0;
      MW_PC4      <= '0;
      MW_RD       <= '0;
      MW_MEMTOREG <= '0;
      MW_REGWRITE <= 1'b0;
      MW_FAULT    <= '0;
      ld_size_q   <= '0;
      ld_off_q    <= '0;
      ld_sx_q     <= 1'b0;
    end else if (!STALL) begin
      MW_VALID    <= EM_VALID;
      MW_RD_VAL   <= EM_ADDR;
      MW_PC4      <= EM_PC4;
      MW_RD       <= EM_RD;
      MW_MEMTOREG <= EM_MEMTOREG;
      MW_REGWRITE <= EM_VALID && EM_REGWRITE && (fault == 2'b00);
      MW_FAULT    <= fault;
      ld_size_q   <= do_load ? EM_MEMREAD : 2'b00;
      ld_off_q    <= EM_ADDR[1:0];
      ld_sx_q     <= EM_DMSE;
    end
  end

  always_comb begin
    case (ld_off_q)
      2'd0:    byte_sel = rdata_q[7:0];
      2'd1:    byte_sel = rdata_q[15:8];
      2'd2:    byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase
    half_sel = ld_off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (ld_size_q)
      2'b01:   MW_MEM_DATA = {{24{ld_sx_q & byte_sel[7]}}, byte_sel};
      2'b10:   MW_MEM_DATA = {{16{ld_sx_q & half_sel[15]}}, half_sel};
      2'b11:   MW_MEM_DATA = rdata_q;
      default: MW_MEM_DATA = '0;
    endcase
  end

endmodule
